// File: rtl/btn_tx_sched_pkg.sv
// Shared types and constants for the push-button UART transmit scheduler.
// Also provides the index-width helper used by its submodules.
package btn_tx_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      BUSY = 2'd2
   } state_t;

   localparam logic [7:0] DEFAULT_BASE_CHAR = 8'h30;

   // Index width for n items; a single item still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ce_tick_gen.sv
// Free-running divider producing a registered one-cycle enable every TICK_DIV clocks.
// Usable for debouncer sampling as well as a baud tick.
module ce_tick_gen
   import btn_tx_sched_pkg::*;
#(
   parameter int TICK_DIV = 250000
) (
   input  logic iClk,
   input  logic iReset,
   output logic oCE
);

   localparam int CW = idx_width(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge iClk) begin
      if (iReset) begin
         count <= '0;
         oCE   <= 1'b0;
      end else begin
         oCE   <= (count == LAST);
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/btn_tx_sched.sv
// Button front end: debouncer sample tick, rising-edge capture, per-button pending
// events, and round-robin sharing of the single UART transmitter.
module btn_tx_sched
   import btn_tx_sched_pkg::*;
#(
   parameter int         N_BTN     = 4,
   parameter int         TICK_DIV  = 250000,
   parameter logic [7:0] BASE_CHAR = DEFAULT_BASE_CHAR
) (
   input  logic             iClk,
   input  logic             iReset,
   input  logic [N_BTN-1:0] iDb,
   output logic             oCE,
   output logic             oTxStart,
   output logic [7:0]       oTxData,
   input  logic             iTxBusy,
   output logic             oDropped
);

   localparam int IW = idx_width(N_BTN);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_BTN - 1);

   state_t           state;
   state_t           next_state;
   logic [N_BTN-1:0] prev;
   logic [N_BTN-1:0] pend;
   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] clr;
   logic [IW-1:0]    gnt;
   logic [IW-1:0]    rr;
   logic             grant;
   logic             accept;

   ce_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .iClk   (iClk),
      .iReset (iReset),
      .oCE    (oCE)
   );

   // First requesting index at or after start, wrapping past the last button.
   function automatic logic [IW-1:0] rr_pick(input logic [N_BTN-1:0] req,
                                             input logic [IW-1:0]    start);
      logic [IW-1:0] pick;
      logic [IW-1:0] idx;
      logic          found;
      pick  = start;
      idx   = start;
      found = 1'b0;
      for (int k = 0; k < N_BTN; k++) begin
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
         idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      return pick;
   endfunction

   assign rise   = iDb & ~prev;
   assign grant  = (state == IDLE) && (|pend);
   assign accept = (state == REQ) && iTxBusy;
   assign clr    = accept ? (N_BTN'(1) << gnt) : '0;

   always_ff @(posedge iClk) begin
      if (iReset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (|pend)   next_state = REQ;
         REQ:     if (iTxBusy) next_state = BUSY;
         BUSY:    if (!iTxBusy) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      oTxStart = (state == REQ);
      oTxData  = (state == REQ) ? BASE_CHAR + 8'(gnt) : 8'h00;
   end

   // A rise in the same cycle as its own clear re-arms the flag, so the set wins.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         prev     <= '1;
         pend     <= '0;
         rr       <= '0;
         gnt      <= '0;
         oDropped <= 1'b0;
      end else begin
         prev     <= iDb;
         pend     <= (pend & ~clr) | rise;
         oDropped <= |(rise & pend & ~clr);
         if (grant) begin
            gnt <= rr_pick(pend, rr);
         end
         if (accept) begin
            rr <= (gnt == LAST_IDX) ? '0 : gnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_btn_tx_sched.sv
// Directed plus randomized bench for btn_tx_sched against a transaction-level model.
// A small UART TX model answers requests with configurable latency and busy length.
module tb_btn_tx_sched;

   localparam int N  = 4;
   localparam int TD = 5;

   logic         iClk = 1'b0;
   logic         iReset = 1'b1;
   logic [N-1:0] iDb = '0;
   logic         iTxBusy = 1'b0;
   logic         oCE;
   logic         oTxStart;
   logic [7:0]   oTxData;
   logic         oDropped;

   int checks = 0;
   int failures = 0;

   logic [N-1:0] m_prev = '1;
   logic [N-1:0] m_pend = '0;
   int           m_rr = 0;
   int           m_txn = -1;
   bit           m_acc = 1'b0;
   int           m_tick = 0;
   bit           m_ce = 1'b0;
   bit           m_dropped = 1'b0;

   int tx_left = 0;
   int tx_delay = -1;
   int tx_lat = 1;
   int tx_len = 3;
   bit tx_off = 1'b0;
   bit tx_stuck = 1'b0;

   logic [7:0] sent[$];
   int         ce_cycles[$];
   int         cyc = 0;
   int         drop_count = 0;

   always #5 iClk = ~iClk;

   btn_tx_sched #(.N_BTN(N), .TICK_DIV(TD), .BASE_CHAR(8'h30)) dut (
      .iClk     (iClk),
      .iReset   (iReset),
      .iDb      (iDb),
      .oCE      (oCE),
      .oTxStart (oTxStart),
      .oTxData  (oTxData),
      .iTxBusy  (iTxBusy),
      .oDropped (oDropped)
   );

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int first_from(input logic [N-1:0] p, input int start);
      for (int k = 0; k < N; k++) begin
         if (p[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   // Reference behaviour for one clock edge, expressed as transactions on a button index.
   task automatic model_edge(input bit rst, input logic [N-1:0] db, input bit busy);
      logic [N-1:0] rise;
      logic [N-1:0] newp;
      int           clear;
      int           g;
      bit           keep;
      if (rst) begin
         m_prev = '1; m_pend = '0; m_rr = 0; m_txn = -1; m_acc = 1'b0;
         m_tick = 0; m_ce = 1'b0; m_dropped = 1'b0;
         return;
      end
      rise  = db & ~m_prev;
      clear = -1;
      if (m_txn < 0) begin
         g = first_from(m_pend, m_rr);
         if (g >= 0) begin
            m_txn = g;
            m_acc = 1'b0;
         end
      end else if (!m_acc) begin
         if (busy) begin
            clear = m_txn;
            m_rr  = (m_txn + 1) % N;
            m_acc = 1'b1;
         end
      end else if (!busy) begin
         m_txn = -1;
         m_acc = 1'b0;
      end
      m_dropped = 1'b0;
      for (int i = 0; i < N; i++) begin
         keep = m_pend[i] && (i != clear);
         if (rise[i] && keep) m_dropped = 1'b1;
         newp[i] = rise[i] || keep;
      end
      m_pend = newp;
      m_prev = db;
      m_ce   = (m_tick == TD - 1);
      m_tick = (m_tick + 1) % TD;
   endtask

   task automatic apply_stimulus(input bit rst, input logic [N-1:0] db);
      bit busy;
      bit exp_start;
      busy = !tx_off && (tx_stuck || tx_left > 0);
      if (!rst && oTxStart === 1'b1 && busy) sent.push_back(oTxData);
      iReset  = rst;
      iDb     = db;
      iTxBusy = busy;
      @(posedge iClk);
      #1;
      model_edge(rst, db, busy);
      exp_start = (m_txn >= 0) && !m_acc;
      check_output("oCE", oCE, m_ce);
      check_output("oTxStart", oTxStart, exp_start);
      if (exp_start) check_output("oTxData", oTxData, 8'(8'h30 + m_txn));
      check_output("oDropped", oDropped, m_dropped);
      cyc = rst ? 0 : cyc + 1;
      if (oCE === 1'b1) ce_cycles.push_back(cyc);
      if (oDropped === 1'b1) drop_count++;
      if (rst) begin
         tx_left  = 0;
         tx_delay = -1;
      end else begin
         if (busy && tx_left > 0) tx_left--;
         if (tx_delay > 0) begin
            tx_delay--;
            if (tx_delay == 0) begin
               tx_left  = tx_len;
               tx_delay = -1;
            end
         end else if (tx_delay < 0 && tx_left == 0 && oTxStart === 1'b1 && !tx_off) begin
            if (tx_lat == 0) tx_left = tx_len;
            else tx_delay = tx_lat;
         end
      end
   endtask

   task automatic reset_dut(input logic [N-1:0] db);
      apply_stimulus(1'b1, db);
      apply_stimulus(1'b1, db);
      apply_stimulus(1'b0, db);
   endtask

   task automatic run(input int n, input logic [N-1:0] db);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, db);
   endtask

   initial begin
      logic [N-1:0] db;
      int           budget;

      apply_stimulus(1'b1, '0);
      apply_stimulus(1'b1, '0);
      check_output("rst_oCE", oCE, 0);
      check_output("rst_oTxStart", oTxStart, 0);
      check_output("rst_oTxData", oTxData, 0);
      check_output("rst_oDropped", oDropped, 0);

      ce_cycles.delete();
      apply_stimulus(1'b0, '0);
      run(14, '0);
      check_output("ce_count", ce_cycles.size(), 3);
      check_output("ce_first", ce_cycles[0], 5);
      check_output("ce_second", ce_cycles[1], 10);
      check_output("ce_third", ce_cycles[2], 15);

      tx_lat = 1; tx_len = 10;
      sent.delete();
      run(1, 4'b0100);
      check_output("press_no_req_yet", oTxStart, 0);
      run(1, 4'b0100);
      check_output("press_req", oTxStart, 1);
      check_output("press_char", oTxData, 8'h32);
      run(20, 4'b0100);
      check_output("single_count", sent.size(), 1);
      check_output("single_char", sent[0], 8'h32);

      reset_dut('0);
      tx_lat = 1; tx_len = 3;
      sent.delete();
      run(30, 4'b1011);
      check_output("rr_count", sent.size(), 3);
      check_output("rr_char0", sent[0], 8'h30);
      check_output("rr_char1", sent[1], 8'h31);
      check_output("rr_char2", sent[2], 8'h33);
      sent.delete();
      run(2, 4'b0000);
      run(40, 4'b1111);
      check_output("rr_all_count", sent.size(), 4);
      check_output("rr_all_first", sent[0], 8'h30);
      check_output("rr_all_last", sent[3], 8'h33);

      sent.delete();
      reset_dut(4'b0001);
      run(15, 4'b0001);
      check_output("held_none", sent.size(), 0);
      run(2, 4'b0000);
      run(15, 4'b0001);
      check_output("repress_count", sent.size(), 1);
      check_output("repress_char", sent[0], 8'h30);

      reset_dut('0);
      sent.delete();
      drop_count = 0;
      tx_lat = 1; tx_len = 25;
      run(3, 4'b0001);
      run(2, 4'b0011);
      run(2, 4'b0001);
      run(2, 4'b0011);
      run(60, 4'b0011);
      check_output("coalesce_drops", drop_count, 1);
      check_output("coalesce_count", sent.size(), 2);
      check_output("coalesce_char1", sent[1], 8'h31);

      reset_dut('0);
      tx_off = 1'b1;
      budget = 0;
      apply_stimulus(1'b0, 4'b0100);
      while (oTxStart !== 1'b1 && budget < 10) begin
         apply_stimulus(1'b0, 4'b0100);
         budget++;
      end
      check_output("mid_req_reached", oTxStart, 1);
      apply_stimulus(1'b1, 4'b0100);
      check_output("mid_reset_start", oTxStart, 0);
      tx_off = 1'b0; tx_lat = 1; tx_len = 3;
      sent.delete();
      run(20, 4'b0100);
      check_output("mid_no_send", sent.size(), 0);

      reset_dut('0);
      db = '0;
      for (int i = 0; i < 3000; i++) begin
         if (tx_left == 0 && tx_delay < 0) begin
            tx_lat = $urandom_range(0, 2);
            tx_len = $urandom_range(1, 6);
         end
         if (!tx_stuck && $urandom_range(0, 99) == 0) tx_stuck = 1'b1;
         else if (tx_stuck && $urandom_range(0, 19) == 0) tx_stuck = 1'b0;
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 5) == 0) db[b] = ~db[b];
         end
         apply_stimulus($urandom_range(0, 249) == 0, db);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/btn_tx_sched.md
# btn_tx_sched

Sequencing controller for the push-button front end of the UART design. It generates the sample-enable tick that clocks a bank of `N_BTN` external debouncers and detects rising edges on their debounced outputs. It queues one pending event per button and shares the single UART transmitter between the buttons with round-robin arbitration, sending one ASCII character per press.

## Interface
- `N_BTN`, 4: number of buttons/debouncers, 1..8.
- `TICK_DIV`, 250000: clock cycles per debouncer sample tick, at least 2.
- `BASE_CHAR`, 8'h30: character sent for button 0. Button i sends `BASE_CHAR + i`, modulo 256.

Ports:
- `iClk`  in  1  system clock.
- `iReset`  in  1  reset. One clock; reset is synchronous and active-high.
- `iDb`  in  N_BTN  debounced button levels from the debouncer bank.
- `oCE`  out  1  one-cycle sample-enable pulse, wired to every debouncer's CE input.
- `oTxStart`  out  1  transmit request to the UART TX.
- `oTxData`  out  8  character to transmit. Valid while `oTxStart`=1.
- `iTxBusy`  in  1  UART TX busy flag.
- `oDropped`  out  1  one-cycle pulse: a press was coalesced into an already-pending event.

## Operation
- **Tick counter**
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - `oCE` is registered and is 1 for exactly the cycle after the counter reaches TICK_DIV-1.
- **Edge detect**
  - `prev` is a register that tracks `iDb` every cycle.
  - `rise[i] = iDb[i] & ~prev[i]`.
  - `prev` resets to all ones, so a button held through reset produces no event.
- **Pending flags**, one per button:
  - `rise[i]` sets `pend[i]`.
  - Acceptance of button i's request clears `pend[i]`.
  - If a rise and the clear of the same index happen in the same cycle, the set wins.
  - `rise[i]` while `pend[i]`=1 and not being cleared that cycle pulses `oDropped`. The event is coalesced.
- **Round-robin pointer `rr`**
  - After a grant to index g, `rr` = (g+1) mod N_BTN.
  - Reset value: 0.
- **FSM states**
  - **IDLE**: `oTxStart`=0. If any `pend` bit is set, select the first set index searching upward from `rr` with wrap-around, latch it as `gnt`, and go to REQ.
  - **REQ**: `oTxStart`=1 and `oTxData` = BASE_CHAR+gnt, both held stable. When `iTxBusy`=1, the request is accepted: clear `pend[gnt]`, update `rr`, and go to BUSY.
  - **BUSY**: `oTxStart`=0. When `iTxBusy`=0, go to IDLE.
- **Reset values**
  - Outputs: `oCE`=0, `oTxStart`=0, `oTxData`=0, `oDropped`=0.
  - Internal: counter=0, `pend`=0, `rr`=0, FSM=IDLE.
- **Reset mid-transaction**: everything returns to reset values and the in-flight request is abandoned. The UART is not waited on.
- **Width rules**
  - The counter is `$clog2(TICK_DIV)` bits.
  - `gnt` and `rr` are `$clog2(N_BTN)` bits, minimum 1.
  - `oTxData` addition is 8-bit and truncates.

## Timing
- **Press-to-request latency**: `iDb[i]` rises before edge k, `pend[i]`=1 after edge k, and `oTxStart`=1 after edge k+1 if the FSM is in IDLE.
- **Acceptance**: the first edge with `iTxBusy`=1 while in REQ. `oTxStart` drops on the next cycle.
- **Back-to-back**: minimum one IDLE cycle between the BUSY→IDLE transition and the next REQ.
- **`oCE` period**: exactly TICK_DIV cycles. The first pulse comes TICK_DIV cycles after reset release.
- **`oDropped`**: asserted in the cycle after the coalesced rise.

## Structure
- Shared package/include, FSM state encodings: IDLE=2'd0, REQ=2'd1, BUSY=2'd2. The default BASE_CHAR also lives there.
- Sub-module `ce_tick_gen`, parameterised by TICK_DIV: the counter plus the registered `oCE`. It is reusable for the UART baud tick.
- The round-robin priority search is a combinational function inside the main module.

## Test plan
- **Tick period**: TICK_DIV=5. `oCE` pulses at cycles 5, 10, 15 after reset release, each 1 cycle wide.
- **Single press**: N_BTN=4, press `iDb[2]`, TX model asserts busy 1 cycle after the request for 10 cycles. One request with `oTxData`=8'h32, then `oTxStart`=0 through BUSY and back to IDLE.
- **Simultaneous presses with round-robin**: `iDb`=4'b1011 rises in one cycle with `rr`=0. Characters sent in order 0x30, 0x31, 0x33. A subsequent press of all four after a grant to index 3 starts from index 0.
- **Held through reset**: `iDb`=4'b0001 during and after reset. No request is issued. A release then re-press of button 0 produces 0x30.
- **Coalesce**: press button 1 twice while `iTxBusy` is stuck at 1 serving another button. `oDropped` pulses once and only one 0x31 is sent.
- **Reset mid-operation**: assert `iReset` in REQ with `iTxBusy`=0. Next cycle `oTxStart`=0, `pend`=0. No character is sent afterwards without a new press.
